// File: rtl/fir_out_conditioner.sv
// -----------------------------------------------------------------------------
// fir_out_conditioner
//
// Output conditioning stage for the fir block. The FIR produces a 36-bit signed
// y_out stream with no backpressure. This block optionally decimates it, rounds
// and scales each kept sample (half toward +inf, then arithmetic right shift)
// and saturates it to OUT_W bits. Results go into a small first-word-fall-through
// FIFO with a valid/ready handshake, so a consumer that stalls for a while does
// not lose data. When the FIFO does overflow, the sample is dropped and a sticky
// flag is raised. Saturation events are counted.
//
// Pipeline:
//   y_in/y_vld --(decimate)--> stage 1: round/shift/saturate --> stage 2: FIFO push
//   A kept sample that is sampled at edge N is visible on dout after edge N+1.
//
// Ports:
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous active-low reset
//   y_in       in   IN_W            signed FIR output sample
//   y_vld      in   1               y_in valid this cycle
//   clr_flags  in   1               synchronous clear of ovf and sat_cnt
//   dout       out  OUT_W           head-of-FIFO sample (0 while FIFO empty)
//   dout_vld   out  1               FIFO not empty
//   dout_rdy   in   1               consumer accepts dout when dout_vld=1
//   level      out  $clog2(DEPTH)+1 FIFO occupancy, 0..DEPTH
//   ovf        out  1               sticky: a sample was dropped on a full FIFO
//   sat_cnt    out  16              saturated kept samples, sticks at 0xFFFF
// -----------------------------------------------------------------------------
module fir_out_conditioner #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8,
  parameter int DECIM = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [IN_W-1:0]   y_in,
  input  logic                     y_vld,
  input  logic                     clr_flags,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [15:0]              sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  // Width of the bits that must all agree with the sign for a value to fit.
  localparam int HW = IN_W - OUT_W + 2;

  // Rounding constant 2^(SHIFT-1); shifting a one up and back down by one
  // yields exactly zero when SHIFT is 0, so no rounding happens then.
  localparam logic [IN_W:0] RND_ONE = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0] RND     = (RND_ONE << SHIFT) >> 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_out_conditioner: DEPTH must be a power of two and >= 2");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("fir_out_conditioner: DECIM must be >= 1");
  end
  if (OUT_W < 2 || OUT_W > IN_W || SHIFT < 0 || SHIFT >= IN_W) begin : g_bad_width
    $error("fir_out_conditioner: need 2 <= OUT_W <= IN_W and 0 <= SHIFT < IN_W");
  end

  // ---------------------------------------------------------------------------
  // Decimation: dcnt counts valid input cycles modulo DECIM; phase 0 is kept.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dcnt;
  logic          keep;

  assign keep = y_vld && (dcnt == '0);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt <= '0;
    end else if (y_vld) begin
      dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 datapath: round, shift, saturate (combinational, registered below)
  // The sum is formed one bit wider than the input so the rounding add can
  // never wrap.
  // ---------------------------------------------------------------------------
  logic signed [IN_W:0]  y_ext;
  logic signed [IN_W:0]  y_sum;
  logic signed [IN_W:0]  y_shr;
  logic [HW-1:0]         y_hi;
  logic                  y_fits;
  logic [OUT_W-1:0]      cond_val;
  logic                  cond_sat;

  assign y_ext = {y_in[IN_W-1], y_in};
  assign y_sum = y_ext + RND;
  assign y_shr = y_sum >>> SHIFT;

  // The result fits in OUT_W bits when every bit from the OUT_W sign position
  // upward is a copy of the sign.
  assign y_hi   = y_shr[IN_W:OUT_W-1];
  assign y_fits = (y_hi == '0) || (y_hi == '1);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cond_val = y_shr[OUT_W-1:0];
    cond_sat = 1'b0;
    if (!y_fits) begin
      cond_sat = 1'b1;
      // Positive overflow clamps to max (0111..), negative to min (1000..).
      cond_val = {y_shr[IN_W], {(OUT_W-1){~y_shr[IN_W]}}};
    end
  end

  logic             s1_vld;
  logic [OUT_W-1:0] s1_data;
  logic             s1_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_sat  <= 1'b0;
    end else begin
      s1_vld <= keep;
      if (keep) begin
        s1_data <= cond_val;
        s1_sat  <= cond_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: FIFO push/pop control
  // A pop makes room in the same cycle, so a full FIFO can still accept a push
  // when the consumer is draining it. An empty FIFO cannot pop (dout_vld=0).
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    cnt;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full = (cnt == LW'(DEPTH));
  assign pop  = dout_vld && dout_rdy;
  assign push = s1_vld && (!full || pop);
  assign drop = s1_vld && full && !pop;

  // NOTE: the storage array has no reset; the pointers and occupancy counter
  // define which entries are meaningful, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= s1_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout_vld = (cnt != '0);
  assign level    = cnt;
  // Forced to zero while empty so the output is clean after reset.
  assign dout     = dout_vld ? mem[rptr] : '0;

  // ---------------------------------------------------------------------------
  // Status flags. A clear and a new event in the same cycle leave the flag set
  // (the clear is applied first, then the event).
  // ---------------------------------------------------------------------------
  logic        sat_event;
  logic [15:0] sat_base;
  logic [15:0] sat_next;

  assign sat_event = s1_vld && s1_sat;

  always_comb begin
    sat_base = clr_flags ? 16'h0000 : sat_cnt;
    sat_next = sat_base;
    if (sat_event && (sat_base != 16'hFFFF)) begin
      sat_next = sat_base + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf     <= 1'b0;
      sat_cnt <= '0;
    end else begin
      sat_cnt <= sat_next;
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_conditioner.sv
// -----------------------------------------------------------------------------
// tb_fir_out_conditioner
//
// Two instances share clock and reset: dut (DECIM=1) covers rounding,
// saturation, flags and FIFO full behaviour; dut3 (DECIM=3) covers decimation
// and restart after a mid-stream reset. Inputs change on the falling edge and
// outputs are observed there too. Expected samples are computed by the bench
// and queued when stimulus is driven, then compared as the DUT pops them.
// -----------------------------------------------------------------------------
module tb_fir_out_conditioner;

  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               reset;

  logic signed [35:0] y_in;
  logic               y_vld;
  logic               clr_flags;
  logic               dout_rdy;
  logic [15:0]        dout;
  logic               dout_vld;
  logic [3:0]         level;
  logic               ovf;
  logic [15:0]        sat_cnt;

  logic signed [35:0] y_in3;
  logic               y_vld3;
  logic               clr3;
  logic               rdy3;
  logic [15:0]        dout3;
  logic               dout_vld3;
  logic [3:0]         level3;
  logic               ovf3;
  logic [15:0]        sat_cnt3;

  always #5 clk = ~clk;

  fir_out_conditioner #(.IN_W(36), .OUT_W(16), .SHIFT(8), .DEPTH(DEPTH), .DECIM(1)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .y_vld(y_vld), .clr_flags(clr_flags),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .level(level),
    .ovf(ovf), .sat_cnt(sat_cnt)
  );

  fir_out_conditioner #(.IN_W(36), .OUT_W(16), .SHIFT(8), .DEPTH(DEPTH), .DECIM(3)) dut3 (
    .clk(clk), .reset(reset), .y_in(y_in3), .y_vld(y_vld3), .clr_flags(clr3),
    .dout(dout3), .dout_vld(dout_vld3), .dout_rdy(rdy3), .level(level3),
    .ovf(ovf3), .sat_cnt(sat_cnt3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference conditioning: floor((y + 128) / 256), clamped to 16-bit signed.
  // Returns {saturated, value}.
  function automatic logic [16:0] ref_cond(input longint y);
    longint s;
    longint q;
    s = y + 128;
    q = s / 256;
    if (s < 0 && (s % 256) != 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(q)};
  endfunction

  // Scoreboards and model state
  logic [15:0] exp_q[$];
  logic [15:0] exp3_q[$];
  bit          m_s1_vld;
  logic [15:0] m_s1_val;
  bit          m_s1_sat;
  bit          m_ovf;
  int          m_sat;
  int          m_dcnt3;
  int          n_out3;

  // Stimulus for the next clock edge
  logic               nxt_vld, nxt_clr, nxt_rdy;
  logic signed [35:0] nxt_y;
  logic               nxt_vld3, nxt_rdy3;
  logic signed [35:0] nxt_y3;

  task automatic clear_model();
    exp_q.delete();
    exp3_q.delete();
    m_s1_vld = 0;
    m_s1_sat = 0;
    m_ovf    = 0;
    m_sat    = 0;
    m_dcnt3  = 0;
  endtask

  // One clock: observe, apply next inputs, advance the expectation model.
  task automatic step();
    logic [16:0] rc;
    logic [15:0] hd;
    bit          popping;
    bit          drop;
    @(negedge clk);
    check("level", level, exp_q.size());
    check("dout_vld", dout_vld, exp_q.size() != 0);
    check("ovf", ovf, m_ovf);
    check("sat_cnt", sat_cnt, m_sat);

    y_vld = nxt_vld; y_in = nxt_y; dout_rdy = nxt_rdy; clr_flags = nxt_clr;
    y_vld3 = nxt_vld3; y_in3 = nxt_y3; rdy3 = nxt_rdy3;

    popping = dout_vld && dout_rdy;
    if (popping && exp_q.size() != 0) begin
      hd = exp_q.pop_front();
      check("dout", dout, hd);
    end
    drop = 0;
    if (m_s1_vld) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(m_s1_val);
      else drop = 1;
    end
    if (nxt_clr) m_sat = 0;
    if (m_s1_vld && m_s1_sat && m_sat < 65535) m_sat++;
    if (drop) m_ovf = 1;
    else if (nxt_clr) m_ovf = 0;
    m_s1_vld = nxt_vld;
    if (nxt_vld) begin
      rc = ref_cond(longint'(nxt_y));
      m_s1_val = rc[15:0];
      m_s1_sat = rc[16];
    end

    if (dout_vld3 && rdy3) begin
      n_out3++;
      if (exp3_q.size() != 0) begin
        hd = exp3_q.pop_front();
        check("dout3", dout3, hd);
      end else begin
        check("dout3_spurious", dout_vld3, 0);
      end
    end
    if (nxt_vld3) begin
      if (m_dcnt3 == 0) begin
        rc = ref_cond(longint'(nxt_y3));
        exp3_q.push_back(rc[15:0]);
      end
      m_dcnt3 = (m_dcnt3 + 1) % 3;
    end
  endtask

  task automatic idle_inputs();
    nxt_vld = 0; nxt_y = '0; nxt_clr = 0;
    nxt_vld3 = 0; nxt_y3 = '0;
  endtask

  task automatic send(input longint y, input logic rdy);
    nxt_vld = 1; nxt_y = 36'(y); nxt_rdy = rdy;
    step();
    nxt_vld = 0;
  endtask

  task automatic idle(input int n, input logic rdy);
    nxt_vld = 0; nxt_rdy = rdy;
    repeat (n) step();
  endtask

  // Assert reset asynchronously on a falling edge, check that everything
  // clears at once, hold for a few cycles, then release.
  task automatic do_reset(input logic vld_during, input int cycles);
    @(negedge clk);
    reset = 0;
    y_vld = vld_during; y_in = 36'sd768; dout_rdy = 1; clr_flags = 0;
    y_vld3 = vld_during; y_in3 = 36'sd768; rdy3 = 1;
    #1;
    check("rst_level_now", level, 0);
    check("rst_level3_now", level3, 0);
    check("rst_dout_vld3_now", dout_vld3, 0);
    clear_model();
    repeat (cycles) begin
      @(negedge clk);
      check("rst_dout_vld", dout_vld, 0);
      check("rst_level", level, 0);
      check("rst_ovf", ovf, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_dout", dout, 0);
      check("rst_level3", level3, 0);
    end
    y_vld = 0; y_vld3 = 0;
    idle_inputs();
    reset = 1;
  endtask

  initial begin
    int lat;
    reset = 0;
    y_in = '0; y_vld = 0; clr_flags = 0; dout_rdy = 0;
    y_in3 = '0; y_vld3 = 0; clr3 = 0; rdy3 = 0;
    n_out3 = 0;
    nxt_rdy = 1; nxt_rdy3 = 1;
    idle_inputs();
    clear_model();

    // 1: reset held with valid input present
    do_reset(1'b1, 3);

    // 2: rounding, consumer always ready
    send(768, 1); send(-384, 1); send(127, 1); send(128, 1);
    idle(4, 1);
    check("round_level_idle", level, 0);

    // 2b: two-cycle latency from a kept sample to dout_vld
    send(1000, 1);
    lat = 0;
    while (lat < 6) begin
      idle(1, 1);
      lat++;
      if (dout_vld) break;
    end
    check("latency", lat, 2);
    idle(2, 1);

    // 3: saturation both ways, then clear
    send(longint'(1) << 23, 1);
    send(-(longint'(1) << 24), 1);
    idle(4, 1);
    check("sat_cnt_two", sat_cnt, 2);
    nxt_clr = 1; idle(1, 1); nxt_clr = 0;
    idle(1, 1);
    check("sat_cnt_cleared", sat_cnt, 0);

    // 3b: clear coinciding with a new saturation event
    send(longint'(1) << 30, 1);
    nxt_clr = 1; idle(1, 1); nxt_clr = 0;
    idle(1, 1);
    check("sat_clr_vs_event", sat_cnt, 1);
    nxt_clr = 1; idle(1, 1); nxt_clr = 0;
    idle(3, 1);

    // 4: overflow on a full FIFO, consumer stalled
    for (int k = 1; k <= 10; k++) send(256 * k, 0);
    idle(3, 0);
    check("full_level", level, 8);
    check("full_ovf", ovf, 1);
    idle(10, 1);
    check("drained_level", level, 0);
    check("ovf_sticky", ovf, 1);
    nxt_clr = 1; idle(1, 1); nxt_clr = 0;
    idle(1, 1);
    check("ovf_cleared", ovf, 0);

    // 5: full FIFO with simultaneous push and pop across pointer wrap
    for (int k = 11; k <= 18; k++) send(256 * k, 0);
    idle(2, 0);
    check("full2_level", level, 8);
    send(256 * 19, 0);
    for (int k = 20; k <= 25; k++) send(256 * k, 1);
    idle(1, 1);
    idle(1, 0);
    check("pushpop_level", level, 8);
    check("pushpop_no_ovf", ovf, 0);
    idle(12, 1);
    check("wrap_drained", level, 0);

    // 6: decimation by 3 on dut3
    nxt_rdy3 = 1;
    for (int k = 0; k <= 8; k++) begin
      nxt_vld3 = 1; nxt_y3 = 36'(256 * k);
      step();
    end
    nxt_vld3 = 0;
    repeat (5) step();
    check("decim_out_count", n_out3, 3);
    check("decim_drained", exp3_q.size(), 0);

    // 6b: queue two decimated samples, leave the counter mid-phase, reset
    nxt_rdy3 = 0;
    for (int k = 1; k <= 5; k++) begin
      nxt_vld3 = 1; nxt_y3 = 36'(256 * k);
      step();
    end
    nxt_vld3 = 0;
    repeat (2) step();
    check("decim_level3_before_rst", level3, 2);
    do_reset(1'b0, 2);
    nxt_rdy3 = 1; nxt_rdy = 1;
    for (int k = 10; k <= 13; k++) begin
      nxt_vld3 = 1; nxt_y3 = 36'(256 * k);
      step();
    end
    nxt_vld3 = 0;
    repeat (5) step();
    check("restart_out_count", n_out3, 5);
    check("restart_drained", exp3_q.size(), 0);
    check("dut3_no_ovf", ovf3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
